// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load over the scan path,
// skewed activation streaming, and column deskew with a validity tag pipeline.
module systolic_array_ctrl #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int NUM_VEC_WIDTH     = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [NUM_VEC_WIDTH-1:0]                   num_vectors,
  input  logic [SYSTOLIC_SIZE-1:0]                   pe_disable_cfg,
  output logic                                       busy,
  output logic                                       done,
  input  logic                                       w_row_valid,
  output logic                                       w_row_ready,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      w_row_data,
  input  logic                                       act_valid,
  output logic                                       act_ready,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  act_data,
  output logic                                       scan_en,
  output logic [SYSTOLIC_SIZE-1:0]                   PE_disable,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      weight_flat,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  activation_flat,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_in_flat,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_out_flat,
  output logic                                       res_valid,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] res_data
);

  localparam int N   = SYSTOLIC_SIZE;
  localparam int AW  = ACTIVATION_WIDTH;
  localparam int PSW = PARTIAL_SUM_WIDTH;
  localparam int TD  = 2 * N + 1;
  localparam int RCW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [RCW-1:0]                   row_cnt_q, row_cnt_d;
  logic [NUM_VEC_WIDTH-1:0]         vec_cnt_q, vec_cnt_d;
  logic [NUM_VEC_WIDTH-1:0]         num_q, num_d;
  logic [N-1:0]                     pe_dis_q, pe_dis_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             w_ready_q, w_ready_d;
  logic                             a_ready_q, a_ready_d;
  logic                             scan_q;
  logic [N*WEIGHT_WIDTH-1:0]        weight_q;
  logic [TD-1:0]                    tag_q;
  logic                             w_hs_s, a_hs_s;

  assign w_hs_s = w_row_valid & w_ready_q;
  assign a_hs_s = act_valid & a_ready_q;

  // Once all N rows are accepted LOAD_W lingers one cycle so the last scan_en pulse stays inside it.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    vec_cnt_d = vec_cnt_q;
    num_d     = num_q;
    pe_dis_d  = pe_dis_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d     = num_vectors;
          pe_dis_d  = pe_disable_cfg;
          row_cnt_d = {RCW{1'b0}};
          vec_cnt_d = {NUM_VEC_WIDTH{1'b0}};
          state_d   = LOAD_W;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (row_cnt_q == RCW'(N)) begin
          state_d = (num_q == {NUM_VEC_WIDTH{1'b0}}) ? DRAIN : STREAM;
        end else if (w_hs_s) begin
          row_cnt_d = row_cnt_q + RCW'(1);
        end else begin
          row_cnt_d = row_cnt_q;
        end
      end
      STREAM: begin
        if (a_hs_s) begin
          vec_cnt_d = vec_cnt_q + NUM_VEC_WIDTH'(1);
          if (vec_cnt_d == num_q) begin
            state_d = DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (tag_q == {TD{1'b0}}) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    w_ready_d = (state_d == LOAD_W) && (row_cnt_d != RCW'(N));
    a_ready_d = (state_d == STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= {RCW{1'b0}};
      vec_cnt_q <= {NUM_VEC_WIDTH{1'b0}};
      num_q     <= {NUM_VEC_WIDTH{1'b0}};
      pe_dis_q  <= {N{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      scan_q    <= 1'b0;
      weight_q  <= {(N*WEIGHT_WIDTH){1'b0}};
      tag_q     <= {TD{1'b0}};
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      num_q     <= num_d;
      pe_dis_q  <= pe_dis_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      scan_q    <= w_hs_s;
      weight_q  <= w_hs_s ? w_row_data : weight_q;
      tag_q     <= {tag_q[TD-2:0], a_hs_s};
    end
  end

  // Row i sees its element i cycles later than row 0; idle cycles shift in zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [AW-1:0] sk_q [i+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) sk_q[k] <= {AW{1'b0}};
      end else begin
        sk_q[0] <= a_hs_s ? act_data[i*AW +: AW] : {AW{1'b0}};
        for (int k = 1; k <= i; k++) sk_q[k] <= sk_q[k-1];
      end
    end
    assign activation_flat[i*AW +: AW] = sk_q[i];
  end

  // Column j emerges j cycles after column 0, so it gets N-j register stages to realign.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int D = N - j;
    logic [PSW-1:0] dsk_q [D];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < D; k++) dsk_q[k] <= {PSW{1'b0}};
      end else begin
        dsk_q[0] <= partial_sum_out_flat[j*PSW +: PSW];
        for (int k = 1; k < D; k++) dsk_q[k] <= dsk_q[k-1];
      end
    end
    assign res_data[j*PSW +: PSW] = dsk_q[D-1];
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign w_row_ready         = w_ready_q;
  assign act_ready           = a_ready_q;
  assign scan_en             = scan_q;
  assign PE_disable          = pe_dis_q;
  assign weight_flat         = weight_q;
  assign partial_sum_in_flat = {(N*PSW){1'b0}};
  assign res_valid           = tag_q[TD-1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl at N=4 with a behavioural weight-stationary array.
module tb_systolic_array_ctrl;

  localparam int N   = 4;
  localparam int WW  = 8;
  localparam int AW  = 8;
  localparam int PSW = WW + AW + $clog2(N);
  localparam int NVW = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [NVW-1:0]     num_vectors = '0;
  logic [N-1:0]       pe_disable_cfg = '0;
  logic               busy, done, w_row_ready, act_ready, scan_en, res_valid;
  logic               w_row_valid = 1'b0;
  logic [N*WW-1:0]    w_row_data = '0;
  logic               act_valid = 1'b0;
  logic [N*AW-1:0]    act_data = '0;
  logic [N-1:0]       PE_disable;
  logic [N*WW-1:0]    weight_flat;
  logic [N*AW-1:0]    activation_flat;
  logic [N*PSW-1:0]   partial_sum_in_flat, partial_sum_out_flat, res_data;

  always #5 clk = ~clk;

  systolic_array_ctrl #(
    .SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AW),
    .PARTIAL_SUM_WIDTH(PSW), .NUM_VEC_WIDTH(NVW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .pe_disable_cfg(pe_disable_cfg), .busy(busy), .done(done),
    .w_row_valid(w_row_valid), .w_row_ready(w_row_ready), .w_row_data(w_row_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .scan_en(scan_en), .PE_disable(PE_disable), .weight_flat(weight_flat),
    .activation_flat(activation_flat), .partial_sum_in_flat(partial_sum_in_flat),
    .partial_sum_out_flat(partial_sum_out_flat), .res_valid(res_valid), .res_data(res_data)
  );

  // Array model: weights shift down from row 0 on scan_en; each PE registers act and psum once.
  logic [WW-1:0]  w_m [N][N];
  logic [AW-1:0]  a_m [N][N];
  logic [PSW-1:0] p_m [N][N];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          w_m[i][j] <= '0; a_m[i][j] <= '0; p_m[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (scan_en) w_m[i][j] <= (i == 0) ? weight_flat[j*WW +: WW] : w_m[i-1][j];
          a_m[i][j] <= (j == 0) ? activation_flat[i*AW +: AW] : a_m[i][j-1];
          p_m[i][j] <= ((i == 0) ? partial_sum_in_flat[j*PSW +: PSW] : p_m[i-1][j])
                       + PSW'((j == 0) ? activation_flat[i*AW +: AW] : a_m[i][j-1]) * PSW'(w_m[i][j]);
        end
    end
  end

  always_comb begin
    partial_sum_out_flat = '0;
    for (int j = 0; j < N; j++) partial_sum_out_flat[j*PSW +: PSW] = p_m[N-1][j];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              hs_cyc[$];
  int              res_cyc[$];
  logic [N*PSW-1:0] res_dat[$];
  int              done_cyc[$];
  logic            done_busy[$];
  int              scan_cnt = 0;
  int              ar_cnt = 0;
  int              viol_cnt = 0;

  always @(negedge clk) begin
    if (act_valid && act_ready) hs_cyc.push_back(cyc);
    if (res_valid) begin
      res_cyc.push_back(cyc);
      res_dat.push_back(res_data);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(busy);
    end
    if (scan_en) scan_cnt <= scan_cnt + 1;
    if (act_ready) ar_cnt <= ar_cnt + 1;
    if ((scan_en && act_ready) || ((activation_flat != '0) && (!busy || w_row_ready)))
      viol_cnt <= viol_cnt + 1;
  end

  logic [145:0] all_out;
  assign all_out = {busy, done, scan_en, w_row_ready, act_ready, res_valid,
                    PE_disable, weight_flat, activation_flat, res_data};

  logic [31:0] id_rows  [4] = '{32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
  logic [31:0] two_rows [4] = '{32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202};
  logic [31:0] abcd_rows[4] = '{32'h0A0B0C0D, 32'h01020304, 32'h05060708, 32'h090A0B0C};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [NVW-1:0] n, input logic [N-1:0] cfg);
    num_vectors = n; pe_disable_cfg = cfg; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] row);
    int k = 0;
    w_row_valid = 1'b1; w_row_data = row;
    @(negedge clk);
    while (!w_row_ready && k < 50) begin @(negedge clk); k++; end
    check_eq("w_row_ready_wait", 160'(w_row_ready), 160'(1));
    tick();
    w_row_valid = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] vec);
    int k = 0;
    act_valid = 1'b1; act_data = vec;
    @(negedge clk);
    while (!act_ready && k < 50) begin @(negedge clk); k++; end
    check_eq("act_ready_wait", 160'(act_ready), 160'(1));
    tick();
    act_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] rows [4], input bit toggle);
    for (int r = 0; r < 4; r++) begin
      send_w(rows[r]);
      if (toggle) tick();
    end
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (!done && k < 200) begin @(negedge clk); k++; end
    check_eq("done_wait", 160'(done), 160'(1));
    tick();
  endtask

  int rb, hb, db, sb, ab;

  task automatic snap();
    rb = res_cyc.size(); hb = hs_cyc.size(); db = done_cyc.size();
    sb = scan_cnt; ab = ar_cnt;
  endtask

  task automatic identity_job(input string pfx);
    snap();
    start_job(8'd2, 4'b1010);
    check_eq({pfx, "_pe_disable"}, 160'(PE_disable), 160'(4'b1010));
    load(id_rows, 1'b0);
    send_a(32'h04030201);
    send_a(32'h08070605);
    wait_done();
    check_eq({pfx, "_res_count"}, 160'(res_cyc.size() - rb), 160'(2));
    check_eq({pfx, "_scan_count"}, 160'(scan_cnt - sb), 160'(4));
    if (res_cyc.size() >= rb + 2 && hs_cyc.size() >= hb + 2 && done_cyc.size() > db) begin
      check_eq({pfx, "_res0"}, 160'(res_dat[rb]), 160'({18'd4, 18'd3, 18'd2, 18'd1}));
      check_eq({pfx, "_res1"}, 160'(res_dat[rb+1]), 160'({18'd8, 18'd7, 18'd6, 18'd5}));
      check_eq({pfx, "_lat0"}, 160'(res_cyc[rb] - hs_cyc[hb]), 160'(9));
      check_eq({pfx, "_lat1"}, 160'(res_cyc[rb+1] - hs_cyc[hb+1]), 160'(9));
      check_eq({pfx, "_done_after_last"}, 160'(done_cyc[db] - res_cyc[rb+1]), 160'(2));
      check_eq({pfx, "_busy_at_done"}, 160'(done_busy[db]), 160'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check_eq("reset_outputs", 160'(all_out), 160'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Identity weights, two back-to-back vectors.
    identity_job("ident");

    // Weights all 2, 3-cycle bubble between two vectors.
    snap();
    start_job(8'd2, 4'b0000);
    load(two_rows, 1'b0);
    send_a(32'h01010101);
    repeat (3) tick();
    send_a(32'h01010101);
    wait_done();
    check_eq("two_res_count", 160'(res_cyc.size() - rb), 160'(2));
    if (res_cyc.size() >= rb + 2 && hs_cyc.size() >= hb + 2) begin
      check_eq("two_res0", 160'(res_dat[rb]), 160'({18'd8, 18'd8, 18'd8, 18'd8}));
      check_eq("two_res1", 160'(res_dat[rb+1]), 160'({18'd8, 18'd8, 18'd8, 18'd8}));
      check_eq("two_hs_gap", 160'(hs_cyc[hb+1] - hs_cyc[hb]), 160'(4));
      check_eq("two_res_gap", 160'(res_cyc[rb+1] - res_cyc[rb]), 160'(4));
      check_eq("two_lat0", 160'(res_cyc[rb] - hs_cyc[hb]), 160'(9));
    end

    // Toggled w_row_valid; first row ends in array row 3.
    snap();
    start_job(8'd2, 4'b0000);
    load(abcd_rows, 1'b1);
    send_a(32'h00000001);
    send_a(32'h01000000);
    wait_done();
    check_eq("tog_scan_count", 160'(scan_cnt - sb), 160'(4));
    check_eq("tog_row3", 160'({w_m[3][3], w_m[3][2], w_m[3][1], w_m[3][0]}), 160'(32'h0A0B0C0D));
    check_eq("tog_row2", 160'({w_m[2][3], w_m[2][2], w_m[2][1], w_m[2][0]}), 160'(32'h01020304));
    check_eq("tog_row1", 160'({w_m[1][3], w_m[1][2], w_m[1][1], w_m[1][0]}), 160'(32'h05060708));
    check_eq("tog_row0", 160'({w_m[0][3], w_m[0][2], w_m[0][1], w_m[0][0]}), 160'(32'h090A0B0C));
    check_eq("tog_res_count", 160'(res_cyc.size() - rb), 160'(2));
    if (res_cyc.size() >= rb + 2) begin
      check_eq("tog_res0", 160'(res_dat[rb]), 160'({18'h09, 18'h0A, 18'h0B, 18'h0C}));
      check_eq("tog_res1", 160'(res_dat[rb+1]), 160'({18'h0A, 18'h0B, 18'h0C, 18'h0D}));
    end

    // Zero-vector job.
    snap();
    start_job(8'd0, 4'b0000);
    load(id_rows, 1'b0);
    wait_done();
    check_eq("zero_act_ready", 160'(ar_cnt - ab), 160'(0));
    check_eq("zero_res_count", 160'(res_cyc.size() - rb), 160'(0));
    check_eq("zero_scan_count", 160'(scan_cnt - sb), 160'(4));
    check_eq("zero_done_count", 160'(done_cyc.size() - db), 160'(1));
    if (done_cyc.size() > db) check_eq("zero_busy_at_done", 160'(done_busy[db]), 160'(0));

    // Start while busy must be ignored.
    snap();
    start_job(8'd1, 4'b1010);
    num_vectors = 8'd5; pe_disable_cfg = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    load(id_rows, 1'b0);
    send_a(32'h04030201);
    wait_done();
    repeat (20) tick();
    check_eq("restart_pe_disable", 160'(PE_disable), 160'(4'b1010));
    check_eq("restart_done_count", 160'(done_cyc.size() - db), 160'(1));
    check_eq("restart_hs_count", 160'(hs_cyc.size() - hb), 160'(1));
    check_eq("restart_res_count", 160'(res_cyc.size() - rb), 160'(1));
    if (res_cyc.size() > rb) check_eq("restart_res0", 160'(res_dat[rb]), 160'({18'd4, 18'd3, 18'd2, 18'd1}));

    // Reset asserted mid-STREAM.
    start_job(8'd3, 4'b1111);
    load(id_rows, 1'b0);
    send_a(32'h04030201);
    send_a(32'h08070605);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outputs", 160'(all_out), 160'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    snap();
    repeat (15) tick();
    check_eq("midrst_no_res", 160'(res_cyc.size() - rb), 160'(0));
    check_eq("midrst_no_done", 160'(done_cyc.size() - db), 160'(0));
    check_eq("midrst_idle", 160'({busy, w_row_ready, act_ready}), 160'(0));
    identity_job("after_rst");

    check_eq("invariant_violations", 160'(viol_cnt), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
